// File: rtl/bundle_splitter.sv
// Splits an aligned fetch packet of LANES instruction slots into a stream of
// single instructions, emitting only the slots whose mask bit is set.
module bundle_splitter #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 32,
    parameter int ILEN   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ADDR_W+LANES+LANES*ILEN:0]     in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ADDR_W+ILEN:0]                 out_data
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                    hold_valid_reg;
    logic [ADDR_W-1:0]       base_reg;
    logic [LANES-1:0]        mask_reg;
    logic                    fault_reg;
    logic [LANES*ILEN-1:0]   insts_reg;

    logic [ADDR_W-1:0]       in_base;
    logic [LANES-1:0]        in_mask;
    logic                    in_fault;
    logic [LANES*ILEN-1:0]   in_insts;

    logic [LANE_W-1:0]       lane_sel;
    logic [LANES-1:0]        mask_clr;
    logic [ADDR_W-1:0]       pc;
    logic [ILEN-1:0]         lane_inst [LANES];
    logic                    out_fire;
    logic                    in_fire;
    logic                    last;

    assign in_insts = in_data[LANES*ILEN-1:0];
    assign in_fault = in_data[LANES*ILEN];
    assign in_mask  = in_data[LANES*ILEN+1 +: LANES];
    assign in_base  = in_data[LANES*ILEN+1+LANES +: ADDR_W];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_inst[gi] = insts_reg[gi*ILEN +: ILEN];
        end
    endgenerate

    // Priority pick: scan downward so the lowest set bit wins.
    always_comb begin
        lane_sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_reg[i]) begin
                lane_sel = LANE_W'(i);
            end
        end
    end

    assign mask_clr  = mask_reg & ~(LANES'(1) << lane_sel);
    assign pc        = base_reg + (ADDR_W'(lane_sel) << 2);
    assign out_valid = hold_valid_reg && !flush;
    assign out_data  = {pc, lane_inst[lane_sel], fault_reg};
    assign out_fire  = out_valid && out_ready;
    // A faulting packet retires after its first emitted slot.
    assign last      = out_fire && (fault_reg || (mask_clr == '0));
    assign in_ready  = !flush && (!hold_valid_reg || last);
    assign in_fire   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_valid_reg <= 1'b0;
            base_reg       <= '0;
            mask_reg       <= '0;
            fault_reg      <= 1'b0;
            insts_reg      <= '0;
        end else if (flush) begin
            hold_valid_reg <= 1'b0;
            mask_reg       <= '0;
        end else begin
            if (out_fire) begin
                mask_reg <= mask_clr;
                if (last) begin
                    hold_valid_reg <= 1'b0;
                end
            end
            // An empty-mask packet is swallowed without touching the holder.
            if (in_fire && (in_mask != '0)) begin
                hold_valid_reg <= 1'b1;
                base_reg       <= in_base;
                mask_reg       <= in_mask;
                fault_reg      <= in_fault;
                insts_reg      <= in_insts;
            end
        end
    end

endmodule

// File: tb/tb_bundle_splitter.sv
// Directed self-checking bench for bundle_splitter (LANES=2 and LANES=4 instances).
module tb_bundle_splitter;

    localparam int AW = 32;
    localparam int IL = 32;
    localparam int IN2_W = AW + 2 + 1 + 2 * IL;
    localparam int IN4_W = AW + 4 + 1 + 4 * IL;
    localparam int OUT_W = AW + IL + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN2_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    logic             in_valid4;
    logic             in_ready4;
    logic [IN4_W-1:0] in_data4;
    logic             out_valid4;
    logic             out_ready4;
    logic [OUT_W-1:0] out_data4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bundle_splitter #(.LANES(2), .ADDR_W(AW), .ILEN(IL)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    bundle_splitter #(.LANES(4), .ADDR_W(AW), .ILEN(IL)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN2_W-1:0] pkt(input logic [31:0] base, input logic [1:0] mask,
                                             input logic fault, input logic [31:0] i0,
                                             input logic [31:0] i1);
        return {base, mask, fault, i1, i0};
    endfunction

    task automatic expect_out(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst, input logic fault);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".pc"},    64'(out_data[OUT_W-1 -: AW]), 64'(pc));
        check({tag, ".inst"},  64'(out_data[IL:1]), 64'(inst));
        check({tag, ".fault"}, 64'(out_data[0]), 64'(fault));
    endtask

    logic [31:0] exp_pc [4];
    logic        exp_rdy [4];
    logic [63:0] held;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
        cyc();
        cyc();
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.out_valid4", 64'(out_valid4), 64'd0);
        rst = 1'b1;
        #1;
        check("post_reset.in_ready", 64'(in_ready), 64'd1);
        check("post_reset.out_valid", 64'(out_valid), 64'd0);

        // Back-to-back packets: one instruction per cycle, no bubble.
        exp_pc  = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        exp_rdy = '{1'b0, 1'b1, 1'b0, 1'b1};
        in_valid = 1'b1;
        in_data  = pkt(32'h1000, 2'b11, 1'b0, 32'hA000_0000, 32'hA000_0001);
        #1;
        check("b2b.in_ready0", 64'(in_ready), 64'd1);
        cyc();
        in_data = pkt(32'h1008, 2'b11, 1'b0, 32'hA000_0002, 32'hA000_0003);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) in_valid = 1'b0;
            #1;
            expect_out($sformatf("b2b[%0d]", k), exp_pc[k], 32'hA000_0000 + 32'(k), 1'b0);
            if (k < 3) check($sformatf("b2b.in_ready[%0d]", k), 64'(in_ready), 64'(exp_rdy[k]));
            cyc();
        end
        check("b2b.drain", 64'(out_valid), 64'd0);

        // Sparse mask, then an empty-mask packet.
        in_valid = 1'b1;
        in_data  = pkt(32'h2000, 2'b10, 1'b0, 32'hB000_0000, 32'hB000_0001);
        cyc();
        in_data  = pkt(32'h2100, 2'b00, 1'b0, 32'hBBBB_0000, 32'hBBBB_0001);
        #1;
        expect_out("sparse", 32'h2004, 32'hB000_0001, 1'b0);
        check("sparse.in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        #1;
        check("empty.no_out", 64'(out_valid), 64'd0);
        check("empty.in_ready", 64'(in_ready), 64'd1);

        // Backpressure: held output stays stable, nothing lost.
        in_valid = 1'b1;
        in_data  = pkt(32'h4000, 2'b11, 1'b0, 32'hC000_0000, 32'hC000_0001);
        cyc();
        in_data   = pkt(32'h4100, 2'b01, 1'b0, 32'hCCCC_0000, 32'hCCCC_0001);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        held = 64'(out_data);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            #1;
            check($sformatf("bp.valid[%0d]", k), 64'(out_valid), 64'd1);
            check($sformatf("bp.stable[%0d]", k), 64'(out_data), held);
            check($sformatf("bp.in_ready[%0d]", k), 64'(in_ready), 64'd0);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        expect_out("bp.lane0", 32'h4000, 32'hC000_0000, 1'b0);
        cyc();
        expect_out("bp.lane1", 32'h4004, 32'hC000_0001, 1'b0);
        cyc();
        check("bp.drain", 64'(out_valid), 64'd0);

        // Fault packet: one output, next packet accepted in the same cycle.
        in_valid = 1'b1;
        in_data  = pkt(32'h3000, 2'b11, 1'b1, 32'hD000_0000, 32'hD000_0001);
        cyc();
        in_data  = pkt(32'h5000, 2'b01, 1'b0, 32'hE000_0000, 32'hE000_0001);
        #1;
        expect_out("fault", 32'h3000, 32'hD000_0000, 1'b1);
        check("fault.in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        #1;
        expect_out("after_fault", 32'h5000, 32'hE000_0000, 1'b0);
        cyc();
        check("after_fault.drain", 64'(out_valid), 64'd0);

        // Flush after lane 0: lane 1 never appears.
        in_valid = 1'b1;
        in_data  = pkt(32'h6000, 2'b11, 1'b0, 32'hF000_0000, 32'hF000_0001);
        cyc();
        in_valid = 1'b0;
        #1;
        expect_out("flush.lane0", 32'h6000, 32'hF000_0000, 1'b0);
        cyc();
        flush = 1'b1;
        #1;
        check("flush.out_valid", 64'(out_valid), 64'd0);
        check("flush.in_ready", 64'(in_ready), 64'd0);
        cyc();
        flush = 1'b0;
        #1;
        check("flush.next_out_valid", 64'(out_valid), 64'd0);
        check("flush.next_in_ready", 64'(in_ready), 64'd1);

        // Address wrap, LANES=2 and LANES=4.
        in_valid = 1'b1;
        in_data  = pkt(32'hFFFF_FFF8, 2'b11, 1'b0, 32'h1111_0000, 32'h1111_0001);
        in_valid4 = 1'b1;
        in_data4  = {32'hFFFF_FFF0, 4'b1000, 1'b0, 32'h4444_0003, 32'h4444_0002,
                     32'h4444_0001, 32'h4444_0000};
        cyc();
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        #1;
        expect_out("wrap.lane0", 32'hFFFF_FFF8, 32'h1111_0000, 1'b0);
        check("wrap4.valid", 64'(out_valid4), 64'd1);
        check("wrap4.pc", 64'(out_data4[OUT_W-1 -: AW]), 64'h0000_0000_FFFF_FFFC);
        check("wrap4.inst", 64'(out_data4[IL:1]), 64'h4444_0003);
        cyc();
        expect_out("wrap.lane1", 32'hFFFF_FFFC, 32'h1111_0001, 1'b0);
        check("wrap4.drain", 64'(out_valid4), 64'd0);
        cyc();

        // Reset mid-packet drops the remaining lane.
        in_valid = 1'b1;
        in_data  = pkt(32'h7000, 2'b11, 1'b0, 32'h7700_0000, 32'h7700_0001);
        cyc();
        in_valid = 1'b0;
        #1;
        expect_out("rstmid.lane0", 32'h7000, 32'h7700_0000, 1'b0);
        cyc();
        rst = 1'b0;
        flush = 1'b1;
        cyc();
        check("rstmid.out_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b1;
        in_data  = pkt(32'h8000, 2'b01, 1'b0, 32'h8800_0000, 32'h8800_0001);
        #1;
        check("rstmid.in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        #1;
        expect_out("rstmid.new", 32'h8000, 32'h8800_0000, 1'b0);
        cyc();
        check("rstmid.drain", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bundle_splitter.md
BUNDLE_SPLITTER -- requirements
Module: bundle_splitter

Interface
REQ-001 The parameter LANES SHALL default to 2 and gives the number of instruction slots per fetch packet; legal values are 1, 2 and 4.
REQ-002 The parameter ADDR_W SHALL default to 32 and gives the address width.
REQ-003 The parameter ILEN SHALL default to 32 and gives the instruction width.
REQ-004 Port clk SHALL be an input of width 1: the single clock, with all state updated on its rising edge.
REQ-005 Port rst SHALL be an input of width 1: synchronous, active-low reset, sampled on the clk rising edge.
REQ-006 Port flush SHALL be an input of width 1: synchronous discard of all held state.
REQ-007 Port in SHALL be a decoupled.in of the packet type: in.valid/in.ready handshake; in.data = {base (ADDR_W), mask (LANES), fault (1), insts (LANES x ILEN)}; base is aligned to LANES*4.
REQ-008 Port out SHALL be a decoupled.out of the instruction type: out.valid/out.ready handshake; out.data = {pc (ADDR_W), inst (ILEN), fault (1)}.

Function
REQ-009 The block SHALL hold at most one packet in a holding register (hold_valid, base, remaining mask, fault, insts); out SHALL be driven only from this register.
REQ-010 out.valid SHALL be hold_valid && !flush.
REQ-011 The emitted lane SHALL be the lowest-indexed set bit of the remaining mask.
REQ-012 out.pc SHALL be base + 4*lane, computed modulo 2^ADDR_W.
REQ-013 out.inst SHALL be insts[lane], and out.fault SHALL be the held fault bit.
REQ-014 On an out handshake (out.valid && out.ready), the emitted lane's bit SHALL be cleared from the remaining mask.
REQ-015 On an out handshake, hold_valid SHALL clear if no mask bits remain after the clear.
REQ-016 A held packet with fault=1 SHALL emit exactly one output, for its lowest set lane, and SHALL then be dropped regardless of any remaining mask bits.
REQ-017 in.ready SHALL be !flush && (!hold_valid || last), where last = out handshake this cycle on the final lane, or on any lane when fault=1.
REQ-018 On an in handshake with mask != 0, the packet SHALL be loaded into the holding register and appear on out the next cycle (latency 1).
REQ-019 On an in handshake with mask == 0, the packet SHALL be consumed and discarded, and the holding register SHALL be left unchanged.
REQ-020 When the final-lane out handshake and an in handshake occur in the same cycle, the new packet SHALL replace the held one with no bubble.
REQ-021 Sustained throughput SHALL be one instruction per cycle while out.ready stays high, with no bubbles between packets.
REQ-022 When out.valid is asserted and out.ready is low, out.data SHALL remain stable and the held state SHALL not change.
REQ-023 The block SHALL be usable directly upstream of the team's fetch queue, with out connected to the queue's enq.
REQ-024 When flush is asserted, hold_valid SHALL clear at the next edge, and no in or out handshake SHALL occur in the flush cycle (in.ready=0, out.valid=0).
REQ-025 When flush and rst assert together, rst SHALL take priority; the resulting state is identical.

Reset
REQ-026 When rst=0 at a clk edge, hold_valid SHALL clear to 0 and the mask, base, fault and insts registers SHALL clear to 0.
REQ-027 During and after reset, out.valid SHALL be 0.
REQ-028 After reset, in.ready SHALL be 1 (when flush=0).
REQ-029 Reset asserted mid-packet SHALL drop the remaining lanes without emitting them.
REQ-030 After rst returns to 1, the block SHALL accept a new packet in the first cycle.

Verification
REQ-031 The bench SHALL cover back-to-back packets: LANES=2, out.ready=1, packets base=0x1000 mask=11 then base=0x1008 mask=11 -> outputs at pc 0x1000, 0x1004, 0x1008, 0x100C on 4 consecutive cycles, with in.ready high on cycles 2 and 4.
REQ-032 The bench SHALL cover a sparse mask: base=0x2000 mask=10 -> a single output at pc 0x2004, inst=insts[1]; a mask=00 packet is accepted and produces no output.
REQ-033 The bench SHALL cover backpressure: out.ready=0 for 3 cycles with the packet held -> out.data stable, in.ready=0, no lane is lost after out.ready rises.
REQ-034 The bench SHALL cover a fault packet: base=0x3000 mask=11 fault=1 -> a single output at pc 0x3000 with fault=1, after which the next packet is accepted in the same cycle.
REQ-035 The bench SHALL cover flush mid-packet: flush after lane 0 of a mask=11 packet -> lane 1 is never emitted, out.valid=0 the next cycle, and in.ready=1 once flush deasserts.
REQ-036 The bench SHALL cover address wrap: base=0xFFFFFFF8 mask=11 -> outputs at pc 0xFFFFFFF8 and 0xFFFFFFFC; with LANES=4, base=0xFFFFFFF0 lane 3 -> pc 0xFFFFFFFC.
